// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
//   Moves one load/store at a time from the MEM stage to the data memory.
//   The memory is 16-bit and word-addressed. Byte stores are done as
//   read-modify-write. Loads return formatted data; faulting requests
//   return a fault response and never touch memory.
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   req_*               request channel (valid/ready); op, byte addr, store data
//   resp_*              response channel (valid/ready); load data, fault flag
//   mem_read/mem_write  memory strobes; mem_addr is the word index
//   mem_wdata/mem_rdata memory write data / combinational read data
module lsu_mem_initiator #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [2:0]  OP_LW  = 3'b000;
    localparam logic [2:0]  OP_LB  = 3'b001;
    localparam logic [2:0]  OP_LBU = 3'b010;
    localparam logic [2:0]  OP_SW  = 3'b100;
    localparam logic [2:0]  OP_SB  = 3'b101;
    localparam logic [16:0] ADDR_LIMIT = 17'(2 * DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  op_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] word_q;
    logic        fault_q;

    logic illegal_op, out_of_range, misaligned, req_fault;
    logic accept;

    always_comb begin
        illegal_op   = !(req_op inside {OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB});
        out_of_range = {1'b0, req_addr} >= ADDR_LIMIT;
        misaligned   = (req_op == OP_LW || req_op == OP_SW) && req_addr[0];
        req_fault    = illegal_op || out_of_range || misaligned;
        accept       = (state == IDLE) && req_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault)            state_nxt = RESP;
                    else if (req_op == OP_SW) state_nxt = WRITE;
                    else                      state_nxt = READ;
                end
            end
            READ:    state_nxt = (op_q == OP_SB) ? WRITE : RESP;
            WRITE:   state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured only on accept; the memory word only in READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                fault_q <= req_fault;
                word_q  <= '0;
            end
            if (state == READ) word_q <= mem_rdata;
        end
    end

    logic [7:0]  sel_byte;
    logic [15:0] merged_word;
    logic [15:0] load_data;

    always_comb begin
        sel_byte    = addr_q[0] ? word_q[15:8] : word_q[7:0];
        merged_word = addr_q[0] ? {wdata_q[7:0], word_q[7:0]}
                                : {word_q[15:8], wdata_q[7:0]};
        case (op_q)
            OP_LW:   load_data = word_q;
            OP_LB:   load_data = {{8{sel_byte[7]}}, sel_byte};
            OP_LBU:  load_data = {8'h00, sel_byte};
            default: load_data = '0;
        endcase
    end

    // All outputs decode from the state register, so an asynchronous reset
    // drops mem_write in the same instant and blocks an in-flight write.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_fault = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: req_ready = 1'b1;
            READ: begin
                mem_read = 1'b1;
                mem_addr = {1'b0, addr_q[15:1]};
            end
            WRITE: begin
                mem_write = 1'b1;
                mem_addr  = {1'b0, addr_q[15:1]};
                mem_wdata = (op_q == OP_SB) ? merged_word : wdata_q;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = fault_q ? 16'h0000 : load_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator
//   Directed bench for lsu_mem_initiator with a 64-word memory model that
//   resets to word15=0x0041, word17=0x0038. A vector table covers loads,
//   stores, byte lanes and faults; hand sequences cover backpressure and
//   reset during a write.
module tb_lsu_mem_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_fault;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_initiator #(.DEPTH_WORDS(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory model: combinational read, commit on posedge, reinit on reset.
    logic [15:0] mem [64];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0000;
            mem[15] <= 16'h0041;
            mem[17] <= 16'h0038;
        end else if (mem_write) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = mem[mem_addr[5:0]];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic        fault;
        int          lat;
        int          nrd;
        int          nwr;
        logic [15:0] saddr;
        logic [15:0] swdata;
    } vec_t;

    vec_t vecs[14];

    task automatic do_req(input vec_t v, input int idx);
        int lat, nrd, nwr;
        bit got;
        lat = 0; nrd = 0; nwr = 0; got = 0;
        @(negedge clk);
        req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        req_valid = 1'b1; resp_ready = 1'b0;
        chk($sformatf("v%0d req_ready_idle", idx), 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            chk($sformatf("v%0d strobes_exclusive", idx), 32'(mem_read & mem_write), 32'd0);
            if (mem_read) begin
                nrd++;
                chk($sformatf("v%0d rd_addr", idx), 32'(mem_addr), 32'(v.saddr));
            end
            if (mem_write) begin
                nwr++;
                chk($sformatf("v%0d wr_addr", idx), 32'(mem_addr), 32'(v.saddr));
                chk($sformatf("v%0d wr_data", idx), 32'(mem_wdata), 32'(v.swdata));
            end
            if (!mem_read && !mem_write)
                chk($sformatf("v%0d idle_bus", idx), 32'({mem_addr, mem_wdata}), 32'd0);
            if (resp_valid) begin
                got = 1;
                lat = c;
            end
        end
        if (!got) begin
            chk($sformatf("v%0d resp_timeout", idx), 32'd0, 32'd1);
            return;
        end
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d n_reads", idx), 32'(nrd), 32'(v.nrd));
        chk($sformatf("v%0d n_writes", idx), 32'(nwr), 32'(v.nwr));
        chk($sformatf("v%0d rdata", idx), 32'(resp_rdata), 32'(v.rdata));
        chk($sformatf("v%0d fault", idx), 32'(resp_fault), 32'(v.fault));
        chk($sformatf("v%0d req_ready_busy", idx), 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d resp_drop", idx), 32'(resp_valid), 32'd0);
        chk($sformatf("v%0d back_idle", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        //         op      addr   wdata    rdata    flt lat rd wr saddr  swdata
        vecs[0]  = '{3'b000, 16'd34,  16'h0000, 16'h0038, 0, 2, 1, 0, 16'd17, 16'h0000};
        vecs[1]  = '{3'b001, 16'd30,  16'h0000, 16'h0041, 0, 2, 1, 0, 16'd15, 16'h0000};
        vecs[2]  = '{3'b010, 16'd34,  16'h0000, 16'h0038, 0, 2, 1, 0, 16'd17, 16'h0000};
        vecs[3]  = '{3'b101, 16'd35,  16'h12AB, 16'h0000, 0, 3, 1, 1, 16'd17, 16'hAB38};
        vecs[4]  = '{3'b000, 16'd34,  16'h0000, 16'hAB38, 0, 2, 1, 0, 16'd17, 16'h0000};
        vecs[5]  = '{3'b001, 16'd35,  16'h0000, 16'hFFAB, 0, 2, 1, 0, 16'd17, 16'h0000};
        vecs[6]  = '{3'b010, 16'd35,  16'h0000, 16'h00AB, 0, 2, 1, 0, 16'd17, 16'h0000};
        vecs[7]  = '{3'b100, 16'd20,  16'hBEEF, 16'h0000, 0, 2, 0, 1, 16'd10, 16'hBEEF};
        vecs[8]  = '{3'b000, 16'd20,  16'h0000, 16'hBEEF, 0, 2, 1, 0, 16'd10, 16'h0000};
        vecs[9]  = '{3'b101, 16'd20,  16'hFF77, 16'h0000, 0, 3, 1, 1, 16'd10, 16'hBE77};
        vecs[10] = '{3'b000, 16'd20,  16'h0000, 16'hBE77, 0, 2, 1, 0, 16'd10, 16'h0000};
        vecs[11] = '{3'b000, 16'd33,  16'h0000, 16'h0000, 1, 1, 0, 0, 16'd0,  16'h0000};
        vecs[12] = '{3'b001, 16'd128, 16'h0000, 16'h0000, 1, 1, 0, 0, 16'd0,  16'h0000};
        vecs[13] = '{3'b011, 16'd34,  16'h0000, 16'h0000, 1, 1, 0, 0, 16'd0,  16'h0000};

        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst resp", 32'({resp_valid, resp_fault, resp_rdata}), 32'd0);
        chk("rst mem", 32'({mem_read, mem_write, mem_addr, mem_wdata}), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) do_req(vecs[i], i);

        // Backpressure: LW 34 held in RESP for 4 cycles, competing request ignored.
        begin
            bit got;
            got = 0;
            @(negedge clk);
            req_op = 3'b000; req_addr = 16'd34; req_valid = 1'b1; resp_ready = 1'b0;
            @(posedge clk);
            #1 req_op = 3'b100; req_addr = 16'd20; req_wdata = 16'h1111;
            for (int c = 0; c < 10 && !got; c++) begin
                @(negedge clk);
                if (resp_valid) got = 1;
            end
            chk("bp resp_seen", 32'(got), 32'd1);
            for (int i = 0; i < 4; i++) begin
                chk("bp resp_valid", 32'(resp_valid), 32'd1);
                chk("bp rdata", 32'(resp_rdata), 32'hBE77 & 32'h0 | 32'hAB38);
                chk("bp req_ready", 32'(req_ready), 32'd0);
                chk("bp strobes", 32'({mem_read, mem_write}), 32'd0);
                @(negedge clk);
            end
            req_valid = 1'b0; resp_ready = 1'b1;
            @(posedge clk);
            #1 resp_ready = 1'b0;
            @(negedge clk);
            chk("bp resp_drop", 32'(resp_valid), 32'd0);
            chk("bp idle", 32'(req_ready), 32'd1);
            chk("bp no_capture_write", 32'(mem[10]), 32'hBE77);
        end

        // Reset while in WRITE for SW 30 <- 0x5555.
        @(negedge clk);
        req_op = 3'b100; req_addr = 16'd30; req_wdata = 16'h5555; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rw in_write", 32'(mem_write), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rw write_drop", 32'(mem_write), 32'd0);
        chk("rw req_ready", 32'(req_ready), 32'd1);
        chk("rw outputs", 32'({resp_valid, mem_read, mem_addr, mem_wdata}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rw no_resp", 32'(resp_valid), 32'd0);
        end
        do_req('{3'b000, 16'd30, 16'h0000, 16'h0041, 0, 2, 1, 0, 16'd15, 16'h0000}, 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
